mul_acc_d: RTL and testbench

Sequential signed fixed-point multiply-accumulate unit for the EKF datapath: computes `(A*B)>>>FRAC + C` over 48-bit Q-format operands using a radix-2 shift-add core. It sits directly upstream of the 48-bit sequential divider and produces the innovation covariance `S = H*P*H' + R` consumed as that divider's divisor. It uses the same single-pulse start/done handshake as the divider, so the two chain with no glue logic.

---
 rtl/mul_acc_d.sv | 160 ++++++++++++++++
 tb/tb_mul_acc_d.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_acc_d.sv
// Sequential signed Q-format multiply-accumulate: result = (A*B)>>>FRAC + C via a radix-2 shift-add core.
// Optional saturation on the final sum is enabled by defining MAC_SAT_EN; otherwise the result wraps.
module mul_acc_d #(
  parameter int W    = 48,
  parameter int FRAC = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         acc_en,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] C,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIN
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [W-1:0]    mcand_reg;
  logic [W-1:0]    mplier_reg;
  logic            sign_reg;
  logic [W-1:0]    addend_reg;
  logic [2*W-1:0]  prod_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [W-1:0]    result_reg;

  logic [W-1:0]    abs_a;
  logic [W-1:0]    abs_b;
  logic [W:0]      step_sum;
  logic [2*W-1:0]  step_prod;
  logic [2*W:0]    prod_mag;
  logic [2*W:0]    prod_signed;
  logic [2*W:0]    prod_shifted;
  logic [2*W+1:0]  fin_sum;
  logic [W-1:0]    fin_result;

  // |-2^(W-1)| wraps back to the same bit pattern, which reads correctly as unsigned 2^(W-1).
  always_comb begin
    abs_a = A[W-1] ? (~A + 1'b1) : A;
    abs_b = B[W-1] ? (~B + 1'b1) : B;
  end

  // One shift-add step: add the multiplicand into the upper half, then shift the whole register right.
  always_comb begin
    step_sum  = {1'b0, prod_reg[2*W-1:W]} + {1'b0, (mplier_reg[0] ? mcand_reg : {W{1'b0}})};
    step_prod = {step_sum, prod_reg[W-1:1]};
  end

  always_comb begin
    prod_mag     = {1'b0, prod_reg};
    prod_signed  = sign_reg ? (~prod_mag + 1'b1) : prod_mag;
    prod_shifted = $unsigned($signed(prod_signed) >>> FRAC);
    fin_sum      = {prod_shifted[2*W], prod_shifted}
                 + {{(W+2){addend_reg[W-1]}}, addend_reg};
    fin_result   = W'(fin_sum);
  end

`ifdef MAC_SAT_EN
  logic            ovf_reg;
  logic            sum_in_range;
  logic [W-1:0]    sat_result;

  // In range when every bit from the sum MSB down to bit W-1 agrees with the sign.
  always_comb begin
    sum_in_range = (fin_sum[2*W+1:W-1] == {(W+3){1'b0}}) ||
                   (fin_sum[2*W+1:W-1] == {(W+3){1'b1}});
    if (sum_in_range) begin
      sat_result = fin_result;
    end else if (fin_sum[2*W+1]) begin
      sat_result = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_result = {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == FIN) begin
      ovf_reg <= !sum_in_range;
    end
  end

  assign ovf = ovf_reg;
`else
  logic [W-1:0]    sat_result;

  always_comb begin
    sat_result = fin_result;
  end

  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      sign_reg   <= 1'b0;
      addend_reg <= '0;
      prod_reg   <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg  <= abs_a;
            mplier_reg <= abs_b;
            sign_reg   <= A[W-1] ^ B[W-1];
            addend_reg <= acc_en ? C : '0;
            prod_reg   <= '0;
            cnt_reg    <= CW'(W-1);
            busy_reg   <= 1'b1;
            state_reg  <= MUL;
          end
        end
        MUL: begin
          prod_reg   <= step_prod;
          mplier_reg <= mplier_reg >> 1;
          if (cnt_reg == '0) begin
            state_reg <= FIN;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        FIN: begin
          result_reg <= sat_result;
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_mul_acc_d.sv
// Self-checking bench for mul_acc_d: directed vector table, protocol sequences and
// randomized operations compared against a plain-arithmetic reference model.
module tb_mul_acc_d;
  localparam int W    = 48;
  localparam int FRAC = 24;
  localparam int LAT  = W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         acc_en = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] C = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  mul_acc_d #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_en(acc_en),
    .A(A), .B(B), .C(C),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         en;
    logic [W-1:0] exp_r;
    logic         exp_o;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: exact signed product, floor division by 2^FRAC, add, then clamp or wrap.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic en,
                                output logic [W-1:0] r, output logic o);
    logic signed [127:0] sa, sb, sc, s, maxv, minv;
    sa = $signed(a);
    sb = $signed(b);
    sc = $signed(c);
    s = (sa * sb) >>> FRAC;
    if (en) s = s + sc;
    maxv = (128'sd1 <<< (W - 1)) - 128'sd1;
    minv = -(128'sd1 <<< (W - 1));
    o = 1'b0;
    r = s[W-1:0];
`ifdef MAC_SAT_EN
    if (s > maxv) begin r = maxv[W-1:0]; o = 1'b1; end
    else if (s < minv) begin r = minv[W-1:0]; o = 1'b1; end
`endif
  endfunction

  // Called just after a rising edge; returns just after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic en);
    logic [63:0] junk;
    A = a; B = b; C = c; acc_en = en; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    junk = {$urandom, $urandom};
    A = junk[W-1:0]; B = ~junk[W-1:0]; C = junk[W-1:0] ^ 48'h5a5a5a5a5a5a;
    acc_en = junk[3];
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic en,
                        input logic [W-1:0] exp_r, input logic exp_o);
    int n;
    start_op(a, b, c, en);
    check({name, "_busy"}, 64'(busy), 64'd1);
    wait_done(n);
    check({name, "_latency"}, 64'(n), 64'(LAT));
    check({name, "_busy_at_done"}, 64'(busy), 64'd0);
    check({name, "_result"}, 64'(result), 64'(exp_r));
    check({name, "_ovf"}, 64'(ovf), 64'(exp_o));
    $display("op %s a=%h b=%h c=%h en=%0d -> result=%h ovf=%0d lat=%0d",
             name, a, b, c, en, result, ovf, n);
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n, n2, seen;
    logic [W-1:0] er;
    logic eo;
    logic [63:0] t1, t2, t3;

    vecs[0] = '{"basic",     48'h000001800000, 48'h000002000000, 48'h0, 1'b0, 48'h000003000000, 1'b0};
    vecs[1] = '{"neg",       48'hFFFFFE800000, 48'h000002000000, 48'h0, 1'b0, 48'hFFFFFD000000, 1'b0};
    vecs[2] = '{"negneg",    48'hFFFFFE800000, 48'hFFFFFE800000, 48'h0, 1'b0, 48'h000002400000, 1'b0};
    vecs[3] = '{"acc",       48'h000000800000, 48'h000000800000, 48'h000001000000, 1'b1, 48'h000001400000, 1'b0};
    vecs[4] = '{"acc_off",   48'h000000800000, 48'h000000800000, 48'h000001000000, 1'b0, 48'h000000400000, 1'b0};
    vecs[5] = '{"trunc_neg", 48'hFFFFFFFFFFFF, 48'h000000000001, 48'h0, 1'b0, 48'hFFFFFFFFFFFF, 1'b0};
    vecs[6] = '{"trunc_pos", 48'h000000000001, 48'h000000000001, 48'h0, 1'b0, 48'h000000000000, 1'b0};
`ifdef MAC_SAT_EN
    vecs[7] = '{"ovf_pos",   48'h7FFFFFFFFFFF, 48'h7FFFFFFFFFFF, 48'h0, 1'b0, 48'h7FFFFFFFFFFF, 1'b1};
    vecs[8] = '{"ovf_neg",   48'h800000000000, 48'h7FFFFFFFFFFF, 48'h0, 1'b0, 48'h800000000000, 1'b1};
`else
    vecs[7] = '{"ovf_pos",   48'h7FFFFFFFFFFF, 48'h7FFFFFFFFFFF, 48'h0, 1'b0, 48'hFFFFFF000000, 1'b0};
    vecs[8] = '{"ovf_neg",   48'h800000000000, 48'h7FFFFFFFFFFF, 48'h0, 1'b0, 48'h000000800000, 1'b0};
`endif

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].en,
             vecs[i].exp_r, vecs[i].exp_o);

    // A start pulse 10 cycles into an operation must be ignored and never queued.
    start_op(48'h000001800000, 48'h000002000000, 48'h0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    A = 48'h123456789ABC; B = 48'hFEDCBA987654; C = 48'h1; acc_en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check("ignored_start_latency", 64'(n + 10), 64'(LAT));
    check("ignored_start_result", 64'(result), 64'h000003000000);
    $display("op ignored_start -> result=%h lat=%0d", result, n + 10);
    seen = 0;
    repeat (60) begin @(posedge clk); #1; if (done) seen++; end
    check("ignored_start_no_queue", 64'(seen), 64'd0);

    // Asynchronous reset 20 cycles into an operation aborts it.
    start_op(48'h000001800000, 48'hFFFFFE800000, 48'h0, 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (60) begin @(posedge clk); #1; if (done) seen++; end
    check("abort_no_done", 64'(seen), 64'd0);
    $display("op abort_at_20 -> busy=%0d result=%h done_pulses=%0d", busy, result, seen);

    // Back-to-back: start issued during the done cycle.
    start_op(48'h000001800000, 48'h000002000000, 48'h0, 1'b0);
    wait_done(n);
    check("b2b_first_latency", 64'(n), 64'(LAT));
    check("b2b_first_result", 64'(result), 64'h000003000000);
    start_op(48'hFFFFFE800000, 48'h000002000000, 48'h0, 1'b0);
    wait_done(n2);
    check("b2b_interval", 64'(n2 + 1), 64'(LAT + 1));
    check("b2b_second_result", 64'(result), 64'hFFFFFD000000);
    $display("op back_to_back -> result=%h interval=%0d", result, n2 + 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      t1 = {$urandom, $urandom};
      t2 = {$urandom, $urandom};
      t3 = {$urandom, $urandom};
      if (i % 3 != 0) begin
        t1 = {{36{t1[27]}}, t1[27:0]};
        t2 = {{36{t2[27]}}, t2[27:0]};
      end
      model(t1[W-1:0], t2[W-1:0], t3[W-1:0], t3[60], er, eo);
      run_op($sformatf("rand%0d", i), t1[W-1:0], t2[W-1:0], t3[W-1:0], t3[60], er, eo);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
